cacheline_adaptor: RTL and testbench

- Bridges the cache's full-line datapath to the 64-bit burst memory bus.
- On a miss fill, it collects s_line/s_burst beats from memory and presents one assembled line to the cache data array.
- On a dirty writeback, it takes one line from the cache data array and emits it as sequential beats.
- Sits between the cache controller / data array and physical memory (or the arbiter).

---
 rtl/cacheline_adaptor_if.sv | 32 +++
 rtl/cacheline_adaptor.sv | 92 +++++++++
 tb/tb_cacheline_adaptor.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_if.sv
// Cache-line side and memory-burst side signals of the cacheline adaptor.
// The slave modport is the adaptor; the master modport is its environment.
interface cacheline_adaptor_if #(
    parameter int s_offset = 5,
    parameter int s_burst  = 64,
    parameter int s_addr   = 32
);
    localparam int s_line = 8 * (2 ** s_offset);

    logic [s_line-1:0]  line_i;
    logic [s_line-1:0]  line_o;
    logic [s_addr-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [s_burst-1:0] burst_i;
    logic [s_burst-1:0] burst_o;
    logic [s_addr-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts between full cache lines and a sequence of memory bus beats:
// assembles fill lines from beats and splits writeback lines into beats.
module cacheline_adaptor #(
    parameter int s_offset = 5,
    parameter int s_burst  = 64,
    parameter int s_addr   = 32
) (
    input logic                clk,
    input logic                rst,
    cacheline_adaptor_if.slave bus
);
    localparam int s_line = 8 * (2 ** s_offset);
    localparam int beats  = s_line / s_burst;
    localparam int cw     = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [cw-1:0]     last_beat = cw'(beats - 1);
    localparam logic [s_addr-1:0] off_mask  = s_addr'((2 ** s_offset) - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    logic [cw-1:0]     count;
    logic [cw-1:0]     count_nx;
    logic [s_line-1:0] buffer;

    always_comb begin
        count_nx = count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            buffer        <= '0;
            bus.line_o    <= '0;
            bus.burst_o   <= '0;
            bus.address_o <= '0;
            bus.read_o    <= 1'b0;
            bus.write_o   <= 1'b0;
            bus.resp_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.resp_o <= 1'b0;
                    count      <= '0;
                    // Writeback wins when both requests arrive together.
                    if (bus.write_i) begin
                        buffer        <= bus.line_i;
                        bus.burst_o   <= bus.line_i[s_burst-1:0];
                        bus.address_o <= bus.address_i & ~off_mask;
                        bus.write_o   <= 1'b1;
                        state         <= WRITE;
                    end else if (bus.read_i) begin
                        bus.address_o <= bus.address_i & ~off_mask;
                        bus.read_o    <= 1'b1;
                        state         <= READ;
                    end
                end
                READ: begin
                    if (bus.resp_i) begin
                        bus.line_o[s_burst*count +: s_burst] <= bus.burst_i;
                        if (count == last_beat) begin
                            count      <= '0;
                            bus.read_o <= 1'b0;
                            bus.resp_o <= 1'b1;
                            state      <= DONE;
                        end else begin
                            count <= count_nx;
                        end
                    end
                end
                WRITE: begin
                    if (bus.resp_i) begin
                        if (count == last_beat) begin
                            count       <= '0;
                            bus.write_o <= 1'b0;
                            bus.resp_o  <= 1'b1;
                            state       <= DONE;
                        end else begin
                            count       <= count_nx;
                            bus.burst_o <= buffer[s_burst*count_nx +: s_burst];
                        end
                    end
                end
                DONE: begin
                    bus.resp_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: table of fill/writeback transactions
// against a scoreboard of expected beats and lines, plus reset and back-to-back sequences.
module tb_cacheline_adaptor;
    localparam int S_OFFSET = 5;
    localparam int S_BURST  = 64;
    localparam int S_ADDR   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adaptor_if #(.s_offset(S_OFFSET), .s_burst(S_BURST), .s_addr(S_ADDR)) bus ();

    cacheline_adaptor #(.s_offset(S_OFFSET), .s_burst(S_BURST), .s_addr(S_ADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit               rd;
        bit               wr;
        logic [31:0]      addr;
        logic [255:0]     line;
        logic [3:0][63:0] data;
        logic [3:0][7:0]  stall;
        logic [31:0]      exp_addr;
        logic [255:0]     exp_line;
        bit               scramble;
    } vec_t;

    vec_t         vecs[5];
    logic [63:0]  burst_q[$];
    logic [255:0] line_q[$];
    logic [255:0] last_fill;
    int           n_cmp;
    int           n_bad;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " line_o"},    bus.line_o,    '0);
        chk({tag, " burst_o"},   bus.burst_o,   '0);
        chk({tag, " address_o"}, bus.address_o, '0);
        chk({tag, " read_o"},    bus.read_o,    '0);
        chk({tag, " write_o"},   bus.write_o,   '0);
        chk({tag, " resp_o"},    bus.resp_o,    '0);
    endtask

    // Starts at a negedge, issues the request, plays memory, checks, and
    // returns at the negedge after the completion pulse.
    task automatic run_txn(input vec_t v);
        int b, st, cyc, lat;
        bit got;
        logic [63:0] exp_beat;
        logic [255:0] exp_line;
        lat = 5;
        for (int i = 0; i < 4; i++) lat += int'(v.stall[i]);
        bus.read_i    = v.rd;
        bus.write_i   = v.wr;
        bus.address_i = v.addr;
        bus.line_i    = v.line;
        if (v.wr) begin
            for (int i = 0; i < 4; i++) burst_q.push_back(v.data[i]);
        end else begin
            line_q.push_back(v.exp_line);
        end
        b = 0; st = 0; cyc = 0; got = 0;
        while (cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (bus.resp_o) begin
                got = 1;
                break;
            end
            if (cyc == 1) chk("address_o", bus.address_o, v.exp_addr);
            if (v.wr) begin
                chk("write_o held", bus.write_o, 1'b1);
                chk("read_o quiet", bus.read_o, 1'b0);
            end else begin
                chk("read_o held", bus.read_o, 1'b1);
                chk("write_o quiet", bus.write_o, 1'b0);
            end
            if (v.scramble && cyc == 2) bus.line_i = {8{$urandom()}};
            bus.resp_i = 1'b0;
            if (b < 4) begin
                if (st < int'(v.stall[b])) begin
                    st++;
                end else begin
                    bus.resp_i = 1'b1;
                    if (v.wr) begin
                        if (burst_q.size() > 0) begin
                            exp_beat = burst_q.pop_front();
                            chk("burst_o", bus.burst_o, exp_beat);
                        end
                    end else begin
                        bus.burst_i = v.data[b];
                    end
                    b++;
                    st = 0;
                end
            end
        end
        chk("resp_o seen", got, 1'b1);
        if (got) begin
            chk("latency", cyc, lat);
            chk("beats used", b, 4);
            chk("read_o at resp", bus.read_o, 1'b0);
            chk("write_o at resp", bus.write_o, 1'b0);
            if (v.wr) begin
                chk("line_o kept", bus.line_o, last_fill);
                chk("burst_q drained", burst_q.size(), 0);
            end else if (line_q.size() > 0) begin
                exp_line = line_q.pop_front();
                chk("line_o", bus.line_o, exp_line);
                last_fill = exp_line;
            end
        end
        burst_q.delete();
        line_q.delete();
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.resp_i  = 1'b0;
        @(negedge clk);
        chk("resp_o one cycle", bus.resp_o, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last_fill = '0;

        vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234, line: '0,
                    data: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    stall: {8'd0, 8'd0, 8'd0, 8'd0}, exp_addr: 32'h0000_1220,
                    exp_line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    scramble: 1'b0};
        vecs[1] = vecs[0];
        vecs[1].stall = {8'd2, 8'd0, 8'd2, 8'd0};
        vecs[2] = '{rd: 1'b0, wr: 1'b1, addr: 32'h8000_003F,
                    line: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                    data: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                    stall: {8'd0, 8'd0, 8'd0, 8'd0}, exp_addr: 32'h8000_0020,
                    exp_line: '0, scramble: 1'b0};
        vecs[3] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_ABCD,
                    line: {64'h0F0E_0D0C_0B0A_0908, 64'h0706_0504_0302_0100,
                           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                    data: {64'h0F0E_0D0C_0B0A_0908, 64'h0706_0504_0302_0100,
                           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                    stall: {8'd0, 8'd0, 8'd1, 8'd0}, exp_addr: 32'h0000_ABC0,
                    exp_line: '0, scramble: 1'b1};
        vecs[4] = '{rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFFF, line: '0,
                    data: {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                           64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001},
                    stall: {8'd1, 8'd0, 8'd3, 8'd0}, exp_addr: 32'hFFFF_FFE0,
                    exp_line: {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                               64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001},
                    scramble: 1'b0};

        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.resp_i    = 1'b0;
        bus.address_i = 32'h1234_5678;
        bus.line_i    = {8{32'hA5A5_5A5A}};
        bus.burst_i   = 64'h0BAD_F00D_0BAD_F00D;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Memory acknowledges while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = {$urandom(), $urandom()};
            @(negedge clk);
            chk("idle read_o", bus.read_o, 1'b0);
            chk("idle write_o", bus.write_o, 1'b0);
            chk("idle resp_o", bus.resp_o, 1'b0);
            chk("idle line_o", bus.line_o, '0);
        end
        bus.resp_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Reset after two accepted fill beats abandons the transaction.
        bus.read_i    = 1'b1;
        bus.address_i = 32'h0000_5678;
        @(negedge clk);
        bus.resp_i  = 1'b1;
        bus.burst_i = 64'h9999_9999_9999_9999;
        @(negedge clk);
        bus.burst_i = 64'h8888_8888_8888_8888;
        @(negedge clk);
        rst = 1'b1;
        bus.burst_i = 64'h7777_7777_7777_7777;
        @(negedge clk);
        chk_all_zero("mid-fill reset");
        rst = 1'b0;
        bus.read_i = 1'b0;
        bus.resp_i = 1'b0;
        last_fill = '0;
        @(negedge clk);
        chk("post-reset resp_o", bus.resp_o, 1'b0);
        run_txn(vecs[0]);

        // Writeback immediately followed by a fill request.
        run_txn(vecs[2]);
        run_txn(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
